// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer between the control unit and a combinational ALU: holds operands
// for a per-opcode latency, captures the 64-bit result into Z and returns it on a valid/ready channel.
module alu_sequencer #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8,
  parameter int ALU_CYCLES = 1
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_opcode,
  input  logic [31:0] req_ry,
  input  logic [31:0] req_rb,
  output logic [31:0] alu_ry,
  output logic [31:0] alu_rb,
  output logic [4:0]  alu_opcode,
  input  logic [63:0] alu_c,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_zhi,
  output logic [31:0] rsp_zlo,
  output logic        rsp_illegal,
  output logic        rsp_div0,
  output logic        busy
);

  localparam logic [4:0] OP_MUL = 5'b01111;
  localparam logic [4:0] OP_DIV = 5'b10000;

  localparam int MAX_A   = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int MAX_LAT = (MAX_A > ALU_CYCLES) ? MAX_A : ALU_CYCLES;
  // The counter holds latency-1, so clog2 of the largest latency is enough.
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [63:0]      z;
  logic             legal;
  logic [CNT_W-1:0] lat_m1;

  always_comb begin
    legal = 1'b0;
    case (req_opcode)
      5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
      5'b01000, 5'b01001, 5'b01010, 5'b01100, 5'b01111,
      5'b10000, 5'b10001, 5'b10010: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    lat_m1 = CNT_W'(ALU_CYCLES - 1);
    if (req_opcode == OP_MUL) begin
      lat_m1 = CNT_W'(MUL_CYCLES - 1);
    end else if (req_opcode == OP_DIV) begin
      lat_m1 = CNT_W'(DIV_CYCLES - 1);
    end
  end

  // Illegal opcodes and divide-by-zero skip EXEC and answer from the accept edge.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state       <= IDLE;
      cnt         <= '0;
      alu_ry      <= '0;
      alu_rb      <= '0;
      alu_opcode  <= '0;
      z           <= '0;
      rsp_illegal <= 1'b0;
      rsp_div0    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            alu_opcode <= req_opcode;
            alu_ry     <= req_ry;
            alu_rb     <= req_rb;
            if (!legal) begin
              z           <= '1;
              rsp_illegal <= 1'b1;
              rsp_div0    <= 1'b0;
              state       <= RESP;
            end else if (req_opcode == OP_DIV && req_rb == 32'd0) begin
              z           <= {req_ry, 32'hFFFF_FFFF};
              rsp_illegal <= 1'b0;
              rsp_div0    <= 1'b1;
              state       <= RESP;
            end else begin
              cnt         <= lat_m1;
              rsp_illegal <= 1'b0;
              rsp_div0    <= 1'b0;
              state       <= EXEC;
            end
          end
        end
        EXEC: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            z     <= alu_c;
            state <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);
  assign rsp_zhi   = z[63:32];
  assign rsp_zlo   = z[31:0];

endmodule
